body_ram_arbiter: RTL and testbench
===================================

Name: body_ram_arbiter

Overview:
Shares one single-port snake-body RAM (one segment's packed Y/X coordinates per word) between three requesters:
- VGA renderer: read-only, highest priority.
- Game update logic: read/write, may lock the RAM for multi-cycle shift sequences.
- Food placer: read-only.
It sits between these requesters and the body RAM, and replaces direct flat-array access to the segment registers.

Parameters:
NUM_PIECES, 64, number of body RAM words (snake segments)
ADDR_BITS, 6, body RAM address width, equal to clog2(NUM_PIECES)
DATA_BITS, 11, packed segment word width (Y in upper bits, X in lower bits)
MAX_LOCK, 16, maximum consecutive cycles Game may hold a lock before it is forcibly broken
STARVE_LIMIT, 4, consecutive denied cycles after which Food outranks Game

Ports:
Clock  in  1  system clock
Reset  in  1  asynchronous, active-high reset
VgaReq  in  1  VGA read request
VgaAddr  in  ADDR_BITS  VGA read address
VgaGnt  out  1  VGA granted this cycle
GameReq  in  1  Game request
GameWe  in  1  Game write enable (qualified by GameGnt)
GameLock  in  1  Game holds the lock while asserted
GameAddr  in  ADDR_BITS  Game address
GameWData  in  DATA_BITS  Game write data
GameGnt  out  1  Game granted this cycle
LockTimeout  out  1  one-cycle pulse when a lock is forcibly broken
FoodReq  in  1  Food read request
FoodAddr  in  ADDR_BITS  Food read address
FoodGnt  out  1  Food granted this cycle
RdData  out  DATA_BITS  read data, shared by all requesters
RdValid  out  3  one-hot {Food,Game,Vga}; tags RdData
RamAddr  out  ADDR_BITS  to RAM
RamWe  out  1  to RAM
RamWData  out  DATA_BITS  to RAM
RamRData  in  DATA_BITS  from RAM, valid 1 cycle after address

Behaviour:
- Reset state:
  - Gnt outputs, RamWe, LockTimeout and RdValid are 0; RdData is 0.
  - RR pointer selects Game.
  - Lock counter and starvation counter are 0.
  - FSM is in ARB.
- Grants:
  - Combinational from the current request inputs and registered state. At most one Gnt per cycle.
  - RamAddr, RamWe and RamWData are muxed combinationally from the granted requester.
  - RamWe = GameGnt & GameWe. All other RAM outputs are 0 when nothing is granted.
- Read return:
  - A read granted in cycle N produces RdValid (the requester's bit) and RdData = RamRData in cycle N+1.
  - Writes never assert RdValid.
- FSM ARB, priority order:
  1. Vga.
  2. Food, if its starvation counter is at or above STARVE_LIMIT.
  3. Round-robin between Game and Food. The pointer toggles to the other requester after each Game or Food grant.
- ARB to LOCKED: a Game grant with GameLock=1 moves the FSM to LOCKED and loads lock count 1.
- FSM LOCKED:
  - Only Game may be granted; Vga and Food are denied.
  - The lock counter increments on every LOCKED cycle.
  - GameLock=0 returns the FSM to ARB on the next cycle.
  - If the counter reaches MAX_LOCK while GameLock is still 1: LockTimeout pulses, the FSM enters COOLDOWN, and Game is not granted that cycle.
- FSM COOLDOWN:
  - Lasts one ARB-rule cycle in which Game is excluded.
  - The FSM then returns to ARB.
  - Game must deassert GameLock to lock again; holding it does not relock.
- Starvation counter:
  - Increments (saturating) each cycle FoodReq=1 and FoodGnt=0.
  - Clears on a Food grant or when FoodReq=0.
- Boundary cases:
  - Simultaneous requests from all three in ARB: Vga wins.
  - No requests: the RR pointer is held.
  - A Game request with GameLock=1 that loses arbitration does not lock.
- Reset mid-transaction: all state clears immediately. A pending RdValid is dropped.

Optional Feature:
BODY_ARB_STATS_EN
- Defined: adds outputs VgaGrantCount, GameGrantCount, FoodGrantCount and LockTimeoutCount, each 16 bits, saturating at 0xFFFF and cleared by Reset.
- Undefined: these ports and their counters do not exist. Arbitration is identical in both builds.

Decomposition:
Shared package holds:
- Segment word pack/unpack helpers (Y above X).
- FSM state encodings: ARB=2'd0, LOCKED=2'd1, COOLDOWN=2'd2.
- RdValid bit indices: VGA=0, GAME=1, FOOD=2.
Natural sub-module: body_arb_priority, the combinational winner-select from the requests, FSM state, RR pointer and starvation flag. The FSM, counters and read-return register stay in the top module.

Test Plan:
- All three requests in the same cycle, ARB, pointer at Game -> VgaGnt=1. The next cycle RdValid=3'b001 and RdData equals the word at VgaAddr.
- Game and Food requesting continuously, no Vga -> grants alternate Game, Food, Game, Food. Each read returns RdValid one cycle later with the correct tag.
- Game writes 11'h1A5 to address 5, then reads address 5 -> RamWe=1 in the write cycle only. RdValid=3'b010 with RdData=11'h1A5 one cycle after the read grant.
- Game holds GameLock for 20 cycles with Vga requesting -> Vga denied for 15 locked cycles. LockTimeout pulses on cycle 16 and VgaGnt=1 the next cycle. Game is not granted again until GameLock drops and re-rises.
- Vga requests for 6 cycles while Game and Food both request -> Food's starvation counter reaches 4. After Vga releases, Food is granted before Game regardless of the RR pointer.
- Reset asserted in the cycle after a granted read -> RdValid=0 immediately. All Gnt outputs are 0, and the FSM is back in ARB after Reset deasserts.

Source files
------------

// File: rtl/body_ram_arbiter_pkg.sv
// Shared types and helpers for the snake-body RAM arbiter: FSM encodings,
// read-return tag bit positions and segment word pack/unpack.
package body_ram_arbiter_pkg;

    localparam int SegXBits = 6;
    localparam int SegYBits = 5;
    localparam int SegBits  = SegYBits + SegXBits;

    typedef enum logic [1:0] {
        ARB      = 2'd0,
        LOCKED   = 2'd1,
        COOLDOWN = 2'd2
    } arbState_t;

    localparam int RdVga  = 0;
    localparam int RdGame = 1;
    localparam int RdFood = 2;

    function automatic logic [SegBits-1:0] packSegment(input logic [SegYBits-1:0] y,
                                                       input logic [SegXBits-1:0] x);
        return {y, x};
    endfunction

    function automatic logic [SegXBits-1:0] segmentX(input logic [SegBits-1:0] word);
        return word[SegXBits-1:0];
    endfunction

    function automatic logic [SegYBits-1:0] segmentY(input logic [SegBits-1:0] word);
        return word[SegBits-1:SegXBits];
    endfunction

endpackage

// File: rtl/body_arb_priority.sv
// Combinational winner select for the body RAM: at most one grant per cycle,
// derived from the live requests and the arbiter's registered state.
module body_arb_priority
    import body_ram_arbiter_pkg::*;
(
    input  logic      arbEnable,
    input  arbState_t state,
    input  logic      vgaReq,
    input  logic      gameReq,
    input  logic      foodReq,
    input  logic      rrGame,
    input  logic      foodStarved,
    input  logic      gameBlocked,
    input  logic      lockExpired,
    output logic      vgaGnt,
    output logic      gameGnt,
    output logic      foodGnt
);

    logic gameEligible;

    always_comb begin
        vgaGnt       = 1'b0;
        gameGnt      = 1'b0;
        foodGnt      = 1'b0;
        // Game sits out the cooldown cycle and any cycle it keeps holding a broken lock.
        gameEligible = gameReq && !gameBlocked && (state != COOLDOWN);
        if (arbEnable) begin
            if (state == LOCKED) begin
                gameGnt = gameReq && !lockExpired;
            end else if (vgaReq) begin
                vgaGnt = 1'b1;
            end else if (foodReq && foodStarved) begin
                foodGnt = 1'b1;
            end else if (gameEligible && (rrGame || !foodReq)) begin
                gameGnt = 1'b1;
            end else begin
                foodGnt = foodReq;
            end
        end
    end

endmodule

// File: rtl/body_ram_arbiter.sv
// Single-port snake-body RAM arbiter for VGA, Game and Food requesters.
// Optional grant/timeout statistics counters are built when BODY_ARB_STATS_EN is defined.
module body_ram_arbiter
    import body_ram_arbiter_pkg::*;
#(
    parameter int NUM_PIECES   = 64,
    parameter int ADDR_BITS    = $clog2(NUM_PIECES),
    parameter int DATA_BITS    = SegBits,
    parameter int MAX_LOCK     = 16,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                 Clock,
    input  logic                 Reset,
    input  logic                 VgaReq,
    input  logic [ADDR_BITS-1:0] VgaAddr,
    output logic                 VgaGnt,
    input  logic                 GameReq,
    input  logic                 GameWe,
    input  logic                 GameLock,
    input  logic [ADDR_BITS-1:0] GameAddr,
    input  logic [DATA_BITS-1:0] GameWData,
    output logic                 GameGnt,
    output logic                 LockTimeout,
    input  logic                 FoodReq,
    input  logic [ADDR_BITS-1:0] FoodAddr,
    output logic                 FoodGnt,
    output logic [DATA_BITS-1:0] RdData,
    output logic [2:0]           RdValid,
    output logic [ADDR_BITS-1:0] RamAddr,
    output logic                 RamWe,
    output logic [DATA_BITS-1:0] RamWData,
`ifdef BODY_ARB_STATS_EN
    output logic [15:0]          VgaGrantCount,
    output logic [15:0]          GameGrantCount,
    output logic [15:0]          FoodGrantCount,
    output logic [15:0]          LockTimeoutCount,
`endif
    input  logic [DATA_BITS-1:0] RamRData
);

    localparam int LockCntBits = $clog2(MAX_LOCK + 1);
    localparam int StarveBits  = $clog2(STARVE_LIMIT + 1);

    arbState_t              state;
    arbState_t              nextState;
    logic [LockCntBits-1:0] lockCnt;
    logic [LockCntBits-1:0] nextLockCnt;
    logic [StarveBits-1:0]  starveCnt;
    logic                   rrGame;
    logic                   lockHold;
    logic [2:0]             rdTag_p0;
    logic [2:0]             rdTag_p1;

    logic vgaGnt;
    logic gameGnt;
    logic foodGnt;
    logic lockExpired;
    logic foodStarved;
    logic gameBlocked;

    assign lockExpired = (state == LOCKED) && GameLock && (lockCnt == LockCntBits'(MAX_LOCK));
    assign foodStarved = (starveCnt >= StarveBits'(STARVE_LIMIT));
    assign gameBlocked = lockHold && GameLock;

    body_arb_priority uPriority (
        .arbEnable   (!Reset),
        .state       (state),
        .vgaReq      (VgaReq),
        .gameReq     (GameReq),
        .foodReq     (FoodReq),
        .rrGame      (rrGame),
        .foodStarved (foodStarved),
        .gameBlocked (gameBlocked),
        .lockExpired (lockExpired),
        .vgaGnt      (vgaGnt),
        .gameGnt     (gameGnt),
        .foodGnt     (foodGnt)
    );

    assign VgaGnt      = vgaGnt;
    assign GameGnt     = gameGnt;
    assign FoodGnt     = foodGnt;
    assign LockTimeout = lockExpired;

    // Stage p0: RAM request mux and read tag for the granted requester
    always_comb begin
        RamAddr  = '0;
        RamWData = '0;
        RamWe    = 1'b0;
        rdTag_p0 = '0;
        if (vgaGnt) begin
            RamAddr         = VgaAddr;
            rdTag_p0[RdVga] = 1'b1;
        end else if (gameGnt) begin
            RamAddr          = GameAddr;
            RamWData         = GameWData;
            RamWe            = GameWe;
            rdTag_p0[RdGame] = !GameWe;
        end else if (foodGnt) begin
            RamAddr          = FoodAddr;
            rdTag_p0[RdFood] = 1'b1;
        end
    end

    always_comb begin
        nextState   = state;
        nextLockCnt = lockCnt;
        case (state)
            ARB: begin
                if (gameGnt && GameLock) begin
                    nextState   = LOCKED;
                    nextLockCnt = LockCntBits'(1);
                end
            end
            LOCKED: begin
                if (!GameLock) begin
                    nextState   = ARB;
                    nextLockCnt = '0;
                end else if (lockExpired) begin
                    nextState   = COOLDOWN;
                    nextLockCnt = '0;
                end else begin
                    nextLockCnt = lockCnt + LockCntBits'(1);
                end
            end
            COOLDOWN: nextState = ARB;
            default: begin
                nextState   = ARB;
                nextLockCnt = '0;
            end
        endcase
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state     <= ARB;
            lockCnt   <= '0;
            starveCnt <= '0;
            rrGame    <= 1'b1;
            lockHold  <= 1'b0;
            rdTag_p1  <= '0;
        end else begin
            state    <= nextState;
            lockCnt  <= nextLockCnt;
            rdTag_p1 <= rdTag_p0;
            if (!FoodReq || foodGnt) begin
                starveCnt <= '0;
            end else if (!foodStarved) begin
                starveCnt <= starveCnt + StarveBits'(1);
            end
            if (gameGnt) begin
                rrGame <= 1'b0;
            end else if (foodGnt) begin
                rrGame <= 1'b1;
            end
            // A broken lock stays latched until Game lets go of GameLock.
            if (lockExpired) begin
                lockHold <= 1'b1;
            end else if (!GameLock) begin
                lockHold <= 1'b0;
            end
        end
    end

    // Stage p1: RAM data returns one cycle after the grant, tagged by requester
    assign RdValid = rdTag_p1;
    assign RdData  = (|rdTag_p1) ? RamRData : '0;

`ifdef BODY_ARB_STATS_EN
    logic [15:0] vgaCount;
    logic [15:0] gameCount;
    logic [15:0] foodCount;
    logic [15:0] timeoutCount;

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            vgaCount     <= '0;
            gameCount    <= '0;
            foodCount    <= '0;
            timeoutCount <= '0;
        end else begin
            if (vgaGnt && (vgaCount != 16'hFFFF)) begin
                vgaCount <= vgaCount + 16'd1;
            end
            if (gameGnt && (gameCount != 16'hFFFF)) begin
                gameCount <= gameCount + 16'd1;
            end
            if (foodGnt && (foodCount != 16'hFFFF)) begin
                foodCount <= foodCount + 16'd1;
            end
            if (lockExpired && (timeoutCount != 16'hFFFF)) begin
                timeoutCount <= timeoutCount + 16'd1;
            end
        end
    end

    assign VgaGrantCount    = vgaCount;
    assign GameGrantCount   = gameCount;
    assign FoodGrantCount   = foodCount;
    assign LockTimeoutCount = timeoutCount;
`endif

endmodule

// File: tb/tb_body_ram_arbiter.sv
// Directed self-checking bench for body_ram_arbiter with a synchronous RAM model.
module tb_body_ram_arbiter;
    import body_ram_arbiter_pkg::*;

    logic        Clock;
    logic        Reset;
    logic        VgaReq;
    logic [5:0]  VgaAddr;
    logic        VgaGnt;
    logic        GameReq;
    logic        GameWe;
    logic        GameLock;
    logic [5:0]  GameAddr;
    logic [10:0] GameWData;
    logic        GameGnt;
    logic        LockTimeout;
    logic        FoodReq;
    logic [5:0]  FoodAddr;
    logic        FoodGnt;
    logic [10:0] RdData;
    logic [2:0]  RdValid;
    logic [5:0]  RamAddr;
    logic        RamWe;
    logic [10:0] RamWData;
    logic [10:0] RamRData;
`ifdef BODY_ARB_STATS_EN
    logic [15:0] VgaGrantCount;
    logic [15:0] GameGrantCount;
    logic [15:0] FoodGrantCount;
    logic [15:0] LockTimeoutCount;
`endif

    logic [10:0] mem [64];
    logic [2:0]  gnts;
    int          checks;
    int          errors;

    assign gnts = {VgaGnt, GameGnt, FoodGnt};

    body_ram_arbiter dut (
        .Clock       (Clock),
        .Reset       (Reset),
        .VgaReq      (VgaReq),
        .VgaAddr     (VgaAddr),
        .VgaGnt      (VgaGnt),
        .GameReq     (GameReq),
        .GameWe      (GameWe),
        .GameLock    (GameLock),
        .GameAddr    (GameAddr),
        .GameWData   (GameWData),
        .GameGnt     (GameGnt),
        .LockTimeout (LockTimeout),
        .FoodReq     (FoodReq),
        .FoodAddr    (FoodAddr),
        .FoodGnt     (FoodGnt),
        .RdData      (RdData),
        .RdValid     (RdValid),
        .RamAddr     (RamAddr),
        .RamWe       (RamWe),
        .RamWData    (RamWData),
`ifdef BODY_ARB_STATS_EN
        .VgaGrantCount    (VgaGrantCount),
        .GameGrantCount   (GameGrantCount),
        .FoodGrantCount   (FoodGrantCount),
        .LockTimeoutCount (LockTimeoutCount),
`endif
        .RamRData    (RamRData)
    );

    function automatic logic [10:0] initWord(input int a);
        return packSegment(5'(31 - (a % 32)), 6'(a));
    endfunction

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    always @(posedge Clock) begin
        if (Reset) begin
            for (int i = 0; i < 64; i++) mem[i] <= initWord(i);
            RamRData <= '0;
        end else begin
            if (RamWe) mem[RamAddr] <= RamWData;
            RamRData <= mem[RamAddr];
        end
    end

    task automatic tick;
        @(posedge Clock);
        #1;
    endtask

    task automatic clearInputs;
        VgaReq = 0; VgaAddr = '0;
        GameReq = 0; GameWe = 0; GameLock = 0; GameAddr = '0; GameWData = '0;
        FoodReq = 0; FoodAddr = '0;
    endtask

    task automatic doReset;
        clearInputs();
        Reset = 1'b1;
        tick();
        tick();
        Reset = 1'b0;
    endtask

    task automatic test_reset;
        clearInputs();
        Reset = 1'b1;
        tick();
        tick();
        checks++; if (gnts !== 3'b000) begin errors++; $display("FAIL reset_gnt: got %b want 000", gnts); end
        checks++; if (RdValid !== 3'b000) begin errors++; $display("FAIL reset_rdvalid: got %b want 000", RdValid); end
        checks++; if (RdData !== 11'h0) begin errors++; $display("FAIL reset_rddata: got %h want 000", RdData); end
        checks++; if ({RamWe, LockTimeout} !== 2'b00) begin errors++; $display("FAIL reset_we_to: got %b want 00", {RamWe, LockTimeout}); end
        checks++; if ({RamAddr, RamWData} !== 17'h0) begin errors++; $display("FAIL reset_ram_bus: got %h want 0", {RamAddr, RamWData}); end
        Reset = 1'b0;
        GameReq = 1; FoodReq = 1;
        #1;
        checks++; if (gnts !== 3'b010) begin errors++; $display("FAIL reset_rr_ptr: got %b want 010", gnts); end
        tick();
        clearInputs();
    endtask

    task automatic test_all_three;
        doReset();
        VgaReq = 1; VgaAddr = 6'd10;
        GameReq = 1; GameAddr = 6'd3;
        FoodReq = 1; FoodAddr = 6'd7;
        #1;
        checks++; if (gnts !== 3'b100) begin errors++; $display("FAIL all3_gnt: got %b want 100", gnts); end
        checks++; if (RamAddr !== 6'd10) begin errors++; $display("FAIL all3_addr: got %0d want 10", RamAddr); end
        tick();
        clearInputs();
        checks++; if (RdValid !== 3'b001) begin errors++; $display("FAIL all3_rdvalid: got %b want 001", RdValid); end
        checks++; if (RdData !== initWord(10)) begin errors++; $display("FAIL all3_rddata: got %h want %h", RdData, initWord(10)); end
    endtask

    task automatic test_round_robin;
        logic [2:0]  expGnt;
        logic [2:0]  expTag;
        logic [5:0]  expAddr;
        doReset();
        GameReq = 1; FoodReq = 1;
        for (int i = 0; i < 6; i++) begin
            GameAddr = 6'(20 + i);
            FoodAddr = 6'(40 + i);
            expGnt  = (i % 2 == 0) ? 3'b010 : 3'b001;
            expTag  = (i % 2 == 0) ? 3'b010 : 3'b100;
            expAddr = (i % 2 == 0) ? 6'(20 + i) : 6'(40 + i);
            #1;
            checks++; if (gnts !== expGnt) begin errors++; $display("FAIL rr_gnt[%0d]: got %b want %b", i, gnts, expGnt); end
            checks++; if (RamAddr !== expAddr) begin errors++; $display("FAIL rr_addr[%0d]: got %0d want %0d", i, RamAddr, expAddr); end
            tick();
            checks++; if (RdValid !== expTag) begin errors++; $display("FAIL rr_tag[%0d]: got %b want %b", i, RdValid, expTag); end
            checks++; if (RdData !== initWord(int'(expAddr))) begin errors++; $display("FAIL rr_data[%0d]: got %h want %h", i, RdData, initWord(int'(expAddr))); end
        end
        clearInputs();
    endtask

    task automatic test_write_read;
        doReset();
        GameReq = 1; GameWe = 1; GameAddr = 6'd5; GameWData = 11'h1A5;
        #1;
        checks++; if ({GameGnt, RamWe} !== 2'b11) begin errors++; $display("FAIL wr_gnt_we: got %b want 11", {GameGnt, RamWe}); end
        checks++; if (RamWData !== 11'h1A5) begin errors++; $display("FAIL wr_wdata: got %h want 1a5", RamWData); end
        tick();
        checks++; if (RdValid !== 3'b000) begin errors++; $display("FAIL wr_no_rdvalid: got %b want 000", RdValid); end
        GameWe = 0; GameWData = '0;
        #1;
        checks++; if ({GameGnt, RamWe} !== 2'b10) begin errors++; $display("FAIL rd_gnt_we: got %b want 10", {GameGnt, RamWe}); end
        tick();
        clearInputs();
        checks++; if (RdValid !== 3'b010) begin errors++; $display("FAIL rd_tag: got %b want 010", RdValid); end
        checks++; if (RdData !== 11'h1A5) begin errors++; $display("FAIL rd_data: got %h want 1a5", RdData); end
    endtask

    task automatic test_lock_timeout;
        doReset();
        GameReq = 1; GameLock = 1; GameAddr = 6'd1;
        #1;
        checks++; if (gnts !== 3'b010) begin errors++; $display("FAIL lock_take: got %b want 010", gnts); end
        tick();
        VgaReq = 1; VgaAddr = 6'd2;
        for (int i = 1; i <= 15; i++) begin
            #1;
            checks++; if ({gnts, LockTimeout} !== 4'b0100) begin errors++; $display("FAIL lock_hold[%0d]: got %b want 0100", i, {gnts, LockTimeout}); end
            tick();
        end
        #1;
        checks++; if ({gnts, LockTimeout} !== 4'b0001) begin errors++; $display("FAIL lock_timeout: got %b want 0001", {gnts, LockTimeout}); end
        tick();
        #1;
        checks++; if ({gnts, LockTimeout} !== 4'b1000) begin errors++; $display("FAIL cooldown_vga: got %b want 1000", {gnts, LockTimeout}); end
        tick();
        VgaReq = 0;
        for (int i = 0; i < 2; i++) begin
            #1;
            checks++; if (gnts !== 3'b000) begin errors++; $display("FAIL no_relock[%0d]: got %b want 000", i, gnts); end
            tick();
        end
        GameLock = 0;
        #1;
        checks++; if (gnts !== 3'b010) begin errors++; $display("FAIL unlock_gnt: got %b want 010", gnts); end
        tick();
        GameLock = 1;
        #1;
        checks++; if (gnts !== 3'b010) begin errors++; $display("FAIL relock_gnt: got %b want 010", gnts); end
        tick();
        VgaReq = 1;
        #1;
        checks++; if (gnts !== 3'b010) begin errors++; $display("FAIL relocked_vga_denied: got %b want 010", gnts); end
        tick();
        GameLock = 0;
        #1;
        checks++; if (gnts !== 3'b010) begin errors++; $display("FAIL release_cycle: got %b want 010", gnts); end
        tick();
        #1;
        checks++; if (gnts !== 3'b100) begin errors++; $display("FAIL back_to_arb: got %b want 100", gnts); end
        tick();
        clearInputs();
    endtask

    task automatic test_starvation;
        doReset();
        VgaReq = 1; GameReq = 1; FoodReq = 1;
        for (int i = 0; i < 6; i++) begin
            #1;
            checks++; if (gnts !== 3'b100) begin errors++; $display("FAIL starve_vga[%0d]: got %b want 100", i, gnts); end
            tick();
        end
        VgaReq = 0;
        #1;
        checks++; if (gnts !== 3'b001) begin errors++; $display("FAIL starve_food_first: got %b want 001", gnts); end
        tick();
        #1;
        checks++; if (gnts !== 3'b010) begin errors++; $display("FAIL starve_then_game: got %b want 010", gnts); end
        tick();
        doReset();
        VgaReq = 1; GameReq = 1; FoodReq = 1;
        tick(); tick(); tick();
        VgaReq = 0;
        #1;
        checks++; if (gnts !== 3'b010) begin errors++; $display("FAIL below_limit_game: got %b want 010", gnts); end
        tick();
        #1;
        checks++; if (gnts !== 3'b001) begin errors++; $display("FAIL below_limit_food: got %b want 001", gnts); end
        tick();
        clearInputs();
    endtask

    task automatic test_reset_mid;
        doReset();
        GameReq = 1; GameLock = 1; GameAddr = 6'd9;
        #1;
        checks++; if (gnts !== 3'b010) begin errors++; $display("FAIL mid_gnt: got %b want 010", gnts); end
        tick();
        checks++; if (RdValid !== 3'b010) begin errors++; $display("FAIL mid_pending: got %b want 010", RdValid); end
        VgaReq = 1; VgaAddr = 6'd4;
        Reset = 1'b1;
        #1;
        checks++; if (RdValid !== 3'b000) begin errors++; $display("FAIL mid_rdvalid_drop: got %b want 000", RdValid); end
        checks++; if (RdData !== 11'h0) begin errors++; $display("FAIL mid_rddata: got %h want 000", RdData); end
        checks++; if (gnts !== 3'b000) begin errors++; $display("FAIL mid_gnt_reset: got %b want 000", gnts); end
        tick();
        Reset = 1'b0;
        #1;
        checks++; if ({gnts, LockTimeout} !== 4'b1000) begin errors++; $display("FAIL mid_arb_after: got %b want 1000", {gnts, LockTimeout}); end
        tick();
        clearInputs();
    endtask

    initial begin
        checks = 0;
        errors = 0;
        Reset  = 1'b1;
        clearInputs();
        test_reset();
        test_all_three();
        test_round_robin();
        test_write_read();
        test_lock_timeout();
        test_starvation();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
